clk_divider_multi: RTL and testbench

Multi-channel, runtime-programmable clock/tick generator; parametrised successor of the single-channel fixed-ratio divider. Each of `CHANNELS` independent channels divides `clk` by a 2..2^DIV_W-1 ratio and produces either a square wave or a one-cycle strobe. Channels are reconfigured through a valid/ready port with glitch-free, period-boundary updates. A common `sync` input phase-aligns all channels. The block sits beside the system clock source and feeds enables and ticks to counters, displays and peripherals.

---
 rtl/clk_divider_multi.sv | 118 +++++++++++
 tb/tb_clk_divider_multi.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_divider_multi.sv
// Multi-channel programmable clock/tick divider with glitch-free, period-boundary reconfiguration.
// All channels share one clock; a valid/ready port retargets one channel's divisor and mode at a time.
module clk_divider_multi #(
   parameter int unsigned CLK_FREQ    = 50_000_000,
   parameter int unsigned CHANNELS    = 4,
   parameter int unsigned DIV_W       = 26,
   parameter int unsigned DEFAULT_DIV = CLK_FREQ
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic [CHANNELS-1:0] en_i,
   input  logic                sync_i,
   input  logic                cfg_valid_i,
   output logic                cfg_ready_o,
   input  logic [3:0]          cfg_ch_i,
   input  logic [DIV_W-1:0]    cfg_div_i,
   input  logic                cfg_mode_i,
   output logic [CHANNELS-1:0] clk_div_o,
   output logic [CHANNELS-1:0] tick_o
);

   localparam logic [DIV_W-1:0] DefDiv = DIV_W'(DEFAULT_DIV);
   localparam logic [DIV_W-1:0] MinDiv = DIV_W'(2);

   logic [DIV_W-1:0]    cnt_q [CHANNELS];
   logic [DIV_W-1:0]    cnt_d [CHANNELS];
   logic [DIV_W-1:0]    div_q [CHANNELS];
   logic [DIV_W-1:0]    div_d [CHANNELS];
   logic [DIV_W-1:0]    pdiv_q [CHANNELS];
   logic [DIV_W-1:0]    pdiv_d [CHANNELS];
   logic [CHANNELS-1:0] mode_q, mode_d, pmode_q, pmode_d, pend_q, pend_d;
   logic [CHANNELS-1:0] clk_q, clk_d, tick_q, tick_d;
   logic [CHANNELS-1:0] hit, wrap;
   logic [15:0]         pend_pad;
   logic                xfer;
   logic [DIV_W-1:0]    cfg_div_c;

   // Out-of-range channel indices read a zero pad bit, so they are always ready.
   assign pend_pad    = 16'(pend_q);
   assign cfg_ready_o = !rst_i && !pend_pad[cfg_ch_i];
   assign xfer        = cfg_valid_i && cfg_ready_o;
   assign cfg_div_c   = (cfg_div_i < MinDiv) ? MinDiv : cfg_div_i;

   always_comb begin
      for (int i = 0; i < CHANNELS; i++) begin
         hit[i]  = xfer && (cfg_ch_i == 4'(i));
         wrap[i] = (cnt_q[i] == div_q[i] - DIV_W'(1));
      end
   end

   always_comb begin
      cnt_d   = cnt_q;
      div_d   = div_q;
      pdiv_d  = pdiv_q;
      mode_d  = mode_q;
      pmode_d = pmode_q;
      pend_d  = pend_q;
      clk_d   = clk_q;
      tick_d  = tick_q;
      for (int i = 0; i < CHANNELS; i++) begin
         if (pend_q[i] && (sync_i || !en_i[i] || wrap[i])) begin
            div_d[i]  = pdiv_q[i];
            mode_d[i] = pmode_q[i];
            pend_d[i] = 1'b0;
         end
         if (sync_i || !en_i[i]) begin
            cnt_d[i]  = '0;
            clk_d[i]  = 1'b0;
            tick_d[i] = 1'b0;
         end else begin
            tick_d[i] = wrap[i];
            cnt_d[i]  = wrap[i] ? '0 : cnt_q[i] + DIV_W'(1);
            clk_d[i]  = mode_q[i] ? wrap[i] : (cnt_q[i] < (div_q[i] >> 1));
         end
         // A running (or sync-restarted) channel only takes the new setting at a period boundary.
         if (hit[i]) begin
            if (!sync_i && !en_i[i]) begin
               div_d[i]  = cfg_div_c;
               mode_d[i] = cfg_mode_i;
            end else begin
               pdiv_d[i]  = cfg_div_c;
               pmode_d[i] = cfg_mode_i;
               pend_d[i]  = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < CHANNELS; i++) begin
            cnt_q[i]  <= '0;
            div_q[i]  <= DefDiv;
            pdiv_q[i] <= DefDiv;
         end
         mode_q  <= '0;
         pmode_q <= '0;
         pend_q  <= '0;
         clk_q   <= '0;
         tick_q  <= '0;
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            cnt_q[i]  <= cnt_d[i];
            div_q[i]  <= div_d[i];
            pdiv_q[i] <= pdiv_d[i];
         end
         mode_q  <= mode_d;
         pmode_q <= pmode_d;
         pend_q  <= pend_d;
         clk_q   <= clk_d;
         tick_q  <= tick_d;
      end
   end

   assign clk_div_o = clk_q;
   assign tick_o    = tick_q;

endmodule

// File: tb/tb_clk_divider_multi.sv
// Bench for clk_divider_multi: hand vector table, directed corner sequences, then random traffic
// checked every cycle against a period-position reference model.
module tb_clk_divider_multi;

   localparam int CH  = 4;
   localparam int DW  = 8;
   localparam int DEF = 4;

   logic          clk = 1'b0;
   logic          rst, sync, cfg_valid, cfg_mode;
   logic [CH-1:0] en;
   logic [3:0]    cfg_ch;
   logic [DW-1:0] cfg_div;
   logic          cfg_ready;
   logic [CH-1:0] clk_div, tick;

   int n_tests = 0;
   int n_fail  = 0;

   clk_divider_multi #(
      .CLK_FREQ   (100),
      .CHANNELS   (CH),
      .DIV_W      (DW),
      .DEFAULT_DIV(DEF)
   ) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .en_i       (en),
      .sync_i     (sync),
      .cfg_valid_i(cfg_valid),
      .cfg_ready_o(cfg_ready),
      .cfg_ch_i   (cfg_ch),
      .cfg_div_i  (cfg_div),
      .cfg_mode_i (cfg_mode),
      .clk_div_o  (clk_div),
      .tick_o     (tick)
   );

   always #5 clk = ~clk;

   // Reference model: position within the current period plus active/shadow settings.
   int            pos [CH];
   int            mdiv [CH];
   int            pdiv [CH];
   bit            mmode [CH];
   bit            pmode [CH];
   bit            mpend [CH];
   logic [CH-1:0] eclk = '0;
   logic [CH-1:0] etick = '0;

   function automatic bit m_ready();
      if (rst) return 1'b0;
      if (int'(cfg_ch) >= CH) return 1'b1;
      return !mpend[cfg_ch];
   endfunction

   task automatic model_step();
      bit rdy, hit, last;
      int cd;
      rdy = m_ready();
      if (rst) begin
         for (int i = 0; i < CH; i++) begin
            pos[i] = 0; mdiv[i] = DEF; pdiv[i] = DEF;
            mmode[i] = 0; pmode[i] = 0; mpend[i] = 0;
         end
         eclk = '0; etick = '0;
         return;
      end
      cd = (int'(cfg_div) < 2) ? 2 : int'(cfg_div);
      for (int i = 0; i < CH; i++) begin
         hit = cfg_valid && rdy && (int'(cfg_ch) == i);
         if (sync || !en[i]) begin
            if (mpend[i]) begin mdiv[i] = pdiv[i]; mmode[i] = pmode[i]; mpend[i] = 0; end
            pos[i] = 0; eclk[i] = 1'b0; etick[i] = 1'b0;
            if (hit && sync) begin pdiv[i] = cd; pmode[i] = cfg_mode; mpend[i] = 1; end
            else if (hit) begin mdiv[i] = cd; mmode[i] = cfg_mode; end
         end else begin
            last     = (pos[i] == mdiv[i] - 1);
            etick[i] = last;
            eclk[i]  = mmode[i] ? last : (pos[i] < mdiv[i] / 2);
            pos[i]   = last ? 0 : pos[i] + 1;
            if (last && mpend[i]) begin mdiv[i] = pdiv[i]; mmode[i] = pmode[i]; mpend[i] = 0; end
            if (hit) begin pdiv[i] = cd; pmode[i] = cfg_mode; mpend[i] = 1; end
         end
      end
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic drive(input logic r, input logic [CH-1:0] e, input logic s, input logic v,
                        input logic [3:0] c, input int d, input logic m);
      rst = r; en = e; sync = s; cfg_valid = v; cfg_ch = c; cfg_div = DW'(d); cfg_mode = m;
   endtask

   // Inputs are driven just after a falling edge; outputs are checked on the next falling edge.
   task automatic cyc();
      #1 chk("cfg_ready", {31'b0, cfg_ready}, {31'b0, m_ready()});
      @(posedge clk);
      model_step();
      @(negedge clk);
      chk("clk_div", 32'(clk_div), 32'(eclk));
      chk("tick", 32'(tick), 32'(etick));
   endtask

   typedef struct {
      logic          rst;
      logic [CH-1:0] en;
      logic          sync;
      logic          v;
      logic [3:0]    ch;
      int            div;
      logic          mode;
      logic [CH-1:0] eclk;
      logic [CH-1:0] etick;
      logic          rdy;
   } vec_t;

   vec_t tbl [17];

   initial begin
      logic          r;
      logic [CH-1:0] prev;
      int            stall, t1, t2, n2, n3, coinc, n0;

      tbl[0]  = '{1'b1, 4'b0000, 1'b0, 1'b0, 4'd0, 0, 1'b0, 4'b0000, 4'b0000, 1'b0};
      tbl[1]  = '{1'b0, 4'b0001, 1'b0, 1'b0, 4'd0, 0, 1'b0, 4'b0001, 4'b0000, 1'b1};
      tbl[2]  = '{1'b0, 4'b0001, 1'b0, 1'b0, 4'd0, 0, 1'b0, 4'b0001, 4'b0000, 1'b1};
      tbl[3]  = '{1'b0, 4'b0001, 1'b0, 1'b0, 4'd0, 0, 1'b0, 4'b0000, 4'b0000, 1'b1};
      tbl[4]  = '{1'b0, 4'b0001, 1'b0, 1'b0, 4'd0, 0, 1'b0, 4'b0000, 4'b0001, 1'b1};
      tbl[5]  = '{1'b0, 4'b0001, 1'b0, 1'b0, 4'd0, 0, 1'b0, 4'b0001, 4'b0000, 1'b1};
      tbl[6]  = '{1'b0, 4'b0001, 1'b0, 1'b0, 4'd0, 0, 1'b0, 4'b0001, 4'b0000, 1'b1};
      tbl[7]  = '{1'b0, 4'b0001, 1'b0, 1'b0, 4'd0, 0, 1'b0, 4'b0000, 4'b0000, 1'b1};
      tbl[8]  = '{1'b0, 4'b0001, 1'b0, 1'b0, 4'd0, 0, 1'b0, 4'b0000, 4'b0001, 1'b1};
      tbl[9]  = '{1'b0, 4'b0001, 1'b0, 1'b1, 4'd1, 5, 1'b0, 4'b0001, 4'b0000, 1'b1};
      tbl[10] = '{1'b0, 4'b0011, 1'b0, 1'b0, 4'd1, 0, 1'b0, 4'b0011, 4'b0000, 1'b1};
      tbl[11] = '{1'b0, 4'b0011, 1'b0, 1'b0, 4'd1, 0, 1'b0, 4'b0010, 4'b0000, 1'b1};
      tbl[12] = '{1'b0, 4'b0011, 1'b0, 1'b0, 4'd1, 0, 1'b0, 4'b0000, 4'b0001, 1'b1};
      tbl[13] = '{1'b0, 4'b0011, 1'b0, 1'b0, 4'd1, 0, 1'b0, 4'b0001, 4'b0000, 1'b1};
      tbl[14] = '{1'b0, 4'b0011, 1'b0, 1'b0, 4'd1, 0, 1'b0, 4'b0001, 4'b0010, 1'b1};
      tbl[15] = '{1'b0, 4'b0011, 1'b0, 1'b0, 4'd1, 0, 1'b0, 4'b0010, 4'b0000, 1'b1};
      tbl[16] = '{1'b0, 4'b0011, 1'b0, 1'b0, 4'd1, 0, 1'b0, 4'b0010, 4'b0001, 1'b1};

      for (int i = 0; i < CH; i++) begin
         pos[i] = 0; mdiv[i] = DEF; pdiv[i] = DEF; mmode[i] = 0; pmode[i] = 0; mpend[i] = 0;
      end

      for (int k = 0; k < $size(tbl); k++) begin
         drive(tbl[k].rst, tbl[k].en, tbl[k].sync, tbl[k].v, tbl[k].ch, tbl[k].div, tbl[k].mode);
         #1 chk("tbl_rdy", {31'b0, cfg_ready}, {31'b0, tbl[k].rdy});
         cyc();
         chk("tbl_clk", 32'(clk_div), 32'(tbl[k].eclk));
         chk("tbl_tick", 32'(tick), 32'(tbl[k].etick));
      end

      // Reconfigure running ch0 (div 4 -> 6), then a second write must stall until the wrap.
      drive(0, 4'b0011, 0, 1, 4'd0, 6, 0);
      #1 chk("acc1_rdy", {31'b0, cfg_ready}, 32'd1);
      cyc();
      drive(0, 4'b0011, 0, 1, 4'd0, 3, 0);
      stall = 0;
      for (int k = 0; k < 10; k++) begin
         #1 r = cfg_ready;
         cyc();
         if (r) break;
         stall++;
      end
      chk("stall_cycles", stall, 3);
      drive(0, 4'b0011, 0, 0, 4'd0, 0, 0);
      t1 = -1; t2 = -1;
      for (int k = 1; k <= 12; k++) begin
         cyc();
         if (tick[0]) begin
            if (t1 < 0) t1 = k;
            else if (t2 < 0) t2 = k;
         end
      end
      chk("div6_first_tick", t1, 5);
      chk("div3_gap", t2 - t1, 3);

      // Pulse mode div 3 on ch2, clamped div 0 -> 2 on ch3.
      drive(0, 4'b0011, 0, 1, 4'd2, 3, 1);
      cyc();
      drive(0, 4'b0011, 0, 1, 4'd3, 0, 1);
      cyc();
      drive(0, 4'b1111, 0, 0, 4'd0, 0, 0);
      n2 = 0; n3 = 0;
      for (int k = 0; k < 12; k++) begin
         cyc();
         chk("pulse_eq", 32'(clk_div[2]), 32'(tick[2]));
         n2 += int'(tick[2]);
         n3 += int'(tick[3]);
      end
      chk("pulse_div3_ticks", n2, 4);
      chk("pulse_div2_ticks", n3, 6);

      // sync with ch0 div 4 and ch1 div 6: rising edges coincide every 12 cycles.
      drive(0, 4'b0000, 0, 1, 4'd0, 4, 0);
      cyc();
      drive(0, 4'b0000, 0, 1, 4'd1, 6, 0);
      cyc();
      drive(0, 4'b0011, 0, 0, 4'd0, 0, 0);
      repeat (7) cyc();
      drive(0, 4'b0011, 1, 0, 4'd0, 0, 0);
      cyc();
      chk("sync_clk", 32'(clk_div), 32'd0);
      chk("sync_tick", 32'(tick), 32'd0);
      drive(0, 4'b0011, 0, 0, 4'd0, 0, 0);
      prev = clk_div; coinc = 0;
      for (int k = 0; k < 24; k++) begin
         cyc();
         if (clk_div[0] && !prev[0] && clk_div[1] && !prev[1]) coinc++;
         prev = clk_div;
      end
      chk("sync_coincide", coinc, 2);

      // Disable ch2 mid-period, then reset with a config pending on ch0.
      drive(0, 4'b0101, 1, 0, 4'd0, 0, 0);
      cyc();
      drive(0, 4'b0101, 0, 1, 4'd0, 7, 0);
      cyc();
      drive(0, 4'b0001, 0, 0, 4'd0, 0, 0);
      #1 chk("pend_rdy", {31'b0, cfg_ready}, 32'd0);
      cyc();
      chk("dis_clk2", 32'(clk_div[2]), 32'd0);
      chk("dis_tick2", 32'(tick[2]), 32'd0);
      drive(1, 4'b0001, 0, 0, 4'd0, 0, 0);
      cyc();
      chk("rst_clk", 32'(clk_div), 32'd0);
      chk("rst_tick", 32'(tick), 32'd0);
      drive(0, 4'b0001, 0, 0, 4'd0, 0, 0);
      #1 chk("rst_rdy", {31'b0, cfg_ready}, 32'd1);
      n0 = 0;
      for (int k = 0; k < 9; k++) begin
         cyc();
         n0 += int'(tick[0]);
      end
      chk("rst_default_div", n0, 2);

      // Random traffic, including out-of-range channels, clamped divisors, sync and reset.
      for (int k = 0; k < 3000; k++) begin
         rst = ($urandom_range(0, 199) == 0);
         if ($urandom_range(0, 15) == 0) en = CH'($urandom);
         sync      = ($urandom_range(0, 39) == 0);
         cfg_valid = 1'($urandom_range(0, 1));
         cfg_ch    = 4'($urandom_range(0, 5));
         cfg_div   = DW'($urandom_range(0, 12));
         cfg_mode  = 1'($urandom_range(0, 1));
         cyc();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
